// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift unit for the MIPS EX stage: shifts an operand by up to STEP
// bits per cycle so the core can drop the full barrel shifter and stall on busy.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             use_shamt,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] rs_amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Handshake: start is taken only while busy is low and flush is low; inputs are
  // sampled on that edge alone. done is a one-cycle pulse and result holds after it
  // until the next accepted start.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [4:0]       rem;
  logic [4:0]       rem_nxt;
  logic [1:0]       op_q;
  logic [1:0]       op_nxt;
  logic [4:0]       amt_sel;
  logic [4:0]       step;
  logic             rs_hi_unused;

  // MIPS uses only the low five bits of rs as the variable shift amount.
  assign rs_hi_unused = ^rs_amt[WIDTH-1:5];

  always_comb begin
    amt_sel = use_shamt ? shamt : rs_amt[4:0];
    if (op == OP_RSV) amt_sel = 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      rem    <= '0;
      op_q   <= OP_SLL;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      rem    <= rem_nxt;
      op_q   <= op_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    rem_nxt    = rem;
    op_nxt     = op_q;
    step       = 5'd0;

    if (flush) begin
      // Squash from any state; result keeps whatever the register currently holds.
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_nxt     = op;
            rem_nxt    = amt_sel;
            result_nxt = data_in;
            state_nxt  = (amt_sel == 5'd0) ? S_DONE : S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_SHIFT: begin
          step = (rem > STEP_AMT) ? STEP_AMT : rem;
          case (op_q)
            OP_SLL:  result_nxt = result << step;
            OP_SRL:  result_nxt = result >> step;
            OP_SRA:  result_nxt = $unsigned($signed(result) >>> step);
            default: result_nxt = result;
          endcase
          rem_nxt = rem - step;
          if (rem_nxt == 5'd0) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
